// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 64;
  localparam int DEFAULT_SLICE = 4;

  // Counter width able to index n slice cycles; never narrower than one bit.
  function automatic int count_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_slice.sv
// Combinational SLICE-bit ripple adder built from per-bit full adders.
module adder_slice
  import adder_pkg::*;
#(
  parameter int SLICE = DEFAULT_SLICE
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  logic carry_chain;

  // Ripple the carry bit by bit, LSB first, through one full adder per bit.
  always_comb begin
    carry_chain = cin;
    sum         = '0;
    for (int i = 0; i < SLICE; i++) begin
      sum[i]      = a[i] ^ b[i] ^ carry_chain;
      carry_chain = (a[i] & b[i]) | (carry_chain & (a[i] ^ b[i]));
    end
    cout = carry_chain;
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that pushes one SLICE-bit chunk per cycle
// through a single ripple slice, chaining the carry between cycles.
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SLICE = DEFAULT_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int N     = WIDTH / SLICE;
  localparam int IDX_W = count_width(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  // A partial final slice would silently drop operand bits, so refuse to build.
  if (WIDTH % SLICE != 0) begin : g_width_check
    $error("nibble_serial_adder: WIDTH must be a multiple of SLICE");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_cout_q, out_cout_d;
  logic             out_ovf_q, out_ovf_d;

  logic [SLICE-1:0]       slice_sum;
  logic                   slice_cout;
  logic [WIDTH+SLICE-1:0] sum_cat;
  logic [WIDTH-1:0]       sum_next;

  adder_slice #(
    .SLICE(SLICE)
  ) u_slice (
    .a    (a_sh_q[SLICE-1:0]),
    .b    (b_sh_q[SLICE-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // New slice result enters at the top while older chunks move toward the LSB.
  always_comb begin
    sum_cat  = {slice_sum, sum_sh_q};
    sum_next = sum_cat[WIDTH+SLICE-1:SLICE];
  end

  // Next-state logic: load operands in IDLE, step one slice per RUN cycle,
  // capture the result on the last slice and hold it until it is taken.
  always_comb begin
    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    sum_sh_d   = sum_sh_q;
    carry_d    = carry_q;
    idx_d      = idx_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    out_sum_d  = out_sum_q;
    out_cout_d = out_cout_q;
    out_ovf_d  = out_ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = in_a;
          b_sh_d  = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          sa_d    = in_a[WIDTH-1];
          sb_d    = in_b[WIDTH-1];
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> SLICE;
        b_sh_d   = b_sh_q >> SLICE;
        sum_sh_d = sum_next;
        carry_d  = slice_cout;
        idx_d    = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d      = '0;
          out_sum_d  = sum_next;
          out_cout_d = slice_cout;
          out_ovf_d  = (sa_q == sb_q) && (sum_next[WIDTH-1] != sa_q);
          state_d    = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset that abandons any operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      sum_sh_q   <= '0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      out_sum_q  <= '0;
      out_cout_q <= 1'b0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      sum_sh_q   <= sum_sh_d;
      carry_q    <= carry_d;
      idx_q      <= idx_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      out_sum_q  <= out_sum_d;
      out_cout_q <= out_cout_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  // Handshake flags decode directly from the registered state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    out_sum   = out_sum_q;
    out_cout  = out_cout_q;
    out_ovf   = out_ovf_q;
  end

endmodule
